// File: rtl/wr_ptr_full.sv
// Write-side pointer and full logic for an async FIFO.
// Binary/Gray write pointer, registered full, overflow pulse.
//
// Ports:
//   Src_clk      write-domain clock (rising edge)
//   rst          synchronous active-low reset
//   wr_en        producer write request
//   sync_rd_gray Gray read pointer, already synchronized
//   wr_addr      memory write address
//   wr_gray_ptr  registered Gray write pointer
//   full         registered full flag
//   overflow     one-cycle pulse: write attempted while full
//   almost_full  registered almost-full flag
//                (port present only with `define WR_ALMOST_FULL_EN)
module wr_ptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  Src_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   sync_rd_gray,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr,
  output logic                  full,
`ifdef WR_ALMOST_FULL_EN
  output logic                  almost_full,
`endif
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (AF_MARGIN < 0 || AF_MARGIN > DEPTH) begin : g_af_chk
    $error("AF_MARGIN out of range");
  end

  logic [ADDR_WIDTH:0] r_bin;
  logic [ADDR_WIDTH:0] r_gray;
  logic                r_full;
  logic                r_ovf;

  logic                w_accept;
  logic [ADDR_WIDTH:0] w_bin_next;
  logic [ADDR_WIDTH:0] w_gray_next;
  logic [ADDR_WIDTH:0] w_full_cmp;
  logic                w_full_next;

  assign w_accept    = wr_en & ~r_full;
  assign w_bin_next  = r_bin
                     + {{ADDR_WIDTH{1'b0}}, w_accept};
  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Full when write pointer is exactly one lap ahead:
  // in Gray form the two MSBs differ, the rest match.
  assign w_full_cmp  = {~sync_rd_gray[ADDR_WIDTH:ADDR_WIDTH-1],
                         sync_rd_gray[ADDR_WIDTH-2:0]};
  assign w_full_next = (w_gray_next == w_full_cmp);

  always_ff @(posedge Src_clk) begin
    if (!rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_full <= w_full_next;
      r_ovf  <= wr_en & r_full;
    end
  end

  assign wr_addr     = r_bin[ADDR_WIDTH-1:0];
  assign wr_gray_ptr = r_gray;
  assign full        = r_full;
  assign overflow    = r_ovf;

`ifdef WR_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_LEVEL =
    (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

  logic [ADDR_WIDTH:0] w_rd_bin;
  logic [ADDR_WIDTH:0] w_level;
  logic                r_af;

  // Gray to binary: each bit is the XOR of itself
  // and every more-significant Gray bit.
  always_comb begin
    w_rd_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      w_rd_bin[i] = ^(sync_rd_gray >> i);
    end
  end

  assign w_level = w_bin_next - w_rd_bin;

  always_ff @(posedge Src_clk) begin
    if (!rst) begin
      r_af <= 1'b0;
    end else begin
      r_af <= (w_level >= AF_LEVEL);
    end
  end

  assign almost_full = r_af;
`endif

endmodule

// File: tb/tb_wr_ptr_full.sv
// Directed self-checking bench for wr_ptr_full
// (ADDR_WIDTH=4, DEPTH=16, AF_MARGIN=2).
module tb_wr_ptr_full;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [4:0] rd_gray;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic       full;
  logic       ovf;
`ifdef WR_ALMOST_FULL_EN
  logic       af;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  wr_ptr_full #(
    .ADDR_WIDTH(4),
    .AF_MARGIN (2)
  ) dut (
    .Src_clk     (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .sync_rd_gray(rd_gray),
    .wr_addr     (wr_addr),
    .wr_gray_ptr (wr_gray),
    .full        (full),
`ifdef WR_ALMOST_FULL_EN
    .almost_full (af),
`endif
    .overflow    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [4:0] mbin;
  logic [4:0] prev;

  initial begin
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_gray = 5'b0;
    step();
    rst = 1'b1;
    chk("init_addr", wr_addr, 0);
    chk("init_full", full, 0);

    // some writes, then a one-edge reset with wr_en high
    wr_en = 1'b1;
    repeat (5) step();
    chk("pre_rst_addr", wr_addr, 5);
    chk("pre_rst_gray", wr_gray, 5'b00111);
    rst = 1'b0;
    step();
    rst = 1'b1;
    wr_en = 1'b0;
    chk("rst_addr", wr_addr, 0);
    chk("rst_gray", wr_gray, 5'b00000);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);

    // fill: 16 writes against read pointer 0
    wr_en = 1'b1;
    repeat (15) step();
    chk("fill15_addr", wr_addr, 15);
    chk("fill15_full", full, 0);
    step();
    chk("fill16_full", full, 1);
    chk("fill16_gray", wr_gray, 5'b11000);
    chk("fill16_addr", wr_addr, 0);
    chk("fill16_ovf", ovf, 0);

    // writes while full are dropped and flagged
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_pulse", ovf, 1);
      chk("ovf_gray", wr_gray, 5'b11000);
    end
    wr_en = 1'b0;
    step();
    chk("ovf_clear", ovf, 0);
    chk("ovf_full", full, 1);

    // one read frees a slot, one write refills
    rd_gray = 5'b00001;
    step();
    chk("rd1_full", full, 0);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    chk("refill_full", full, 1);
    chk("refill_gray", wr_gray, 5'b11001);
    step();
    chk("refill_ovf", ovf, 0);

    // 40 writes with reader two cycles behind
    rst = 1'b0;
    rd_gray = 5'b0;
    step();
    rst = 1'b1;
    mbin = 5'd0;
    prev = 5'd0;
    wr_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      mbin = mbin + 5'd1;
      chk("wrap_full", full, 0);
      chk("wrap_gray", wr_gray, gray(mbin));
      chk("wrap_1bit", $countones(wr_gray ^ prev), 1);
      if (k == 32) chk("wrap_zero", wr_gray, 5'b00000);
      if (k == 31) chk("wrap_31", wr_gray, 5'b10000);
      prev = wr_gray;
      rd_gray = (k >= 2) ? gray(mbin - 5'd2) : 5'd0;
    end
    wr_en = 1'b0;

`ifdef WR_ALMOST_FULL_EN
    rst = 1'b0;
    rd_gray = 5'b0;
    step();
    rst = 1'b1;
    chk("af_rst", af, 0);
    wr_en = 1'b1;
    repeat (13) step();
    chk("af13", af, 0);
    step();
    wr_en = 1'b0;
    chk("af14", af, 1);
    chk("af14_full", full, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_ptr_full.md
WR_PTR_FULL -- requirements
Module: wr_ptr_full

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, FIFO address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter AF_MARGIN, default 2, free-slot count at or below which almost_full asserts (used only under WR_ALMOST_FULL_EN).
REQ-003 SHALL have port Src_clk  input  1  write-domain clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write request from producer.
REQ-006 SHALL have port sync_rd_gray  input  ADDR_WIDTH+1  read pointer, Gray-coded, already two-flop synchronized into Src_clk domain.
REQ-007 SHALL have port wr_addr  output  ADDR_WIDTH  memory write address (low bits of binary write pointer).
REQ-008 SHALL have port wr_gray_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent bit-wise to read-domain synchronizers.
REQ-009 SHALL have port full  output  1  registered full flag.
REQ-010 SHALL have port overflow  output  1  one-cycle pulse on write request while full.
REQ-011 SHALL have port almost_full  output  1  registered almost-full flag (present only under WR_ALMOST_FULL_EN).

Function
REQ-012 SHALL keep a binary write pointer wr_bin of ADDR_WIDTH+1 bits; wr_addr = wr_bin[ADDR_WIDTH-1:0].
REQ-013 SHALL accept a write when wr_en=1 and full=0 at the edge; wr_bin_next = wr_bin+1, else wr_bin_next = wr_bin.
REQ-014 SHALL wrap wr_bin modulo 2**(ADDR_WIDTH+1) with no special handling (all-ones+1 = 0).
REQ-015 SHALL compute wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1) and register it into wr_gray_ptr on the same edge wr_bin updates; wr_gray_ptr never changes more than one bit per cycle.
REQ-016 SHALL register full = (wr_gray_next == {~sync_rd_gray[ADDR_WIDTH:ADDR_WIDTH-1], sync_rd_gray[ADDR_WIDTH-2:0]}) every edge.
REQ-017 SHALL assert full on the same edge that accepts the DEPTH-th outstanding write (zero-cycle lag from the write side).
REQ-018 SHALL deassert full one edge after sync_rd_gray advances (pessimistic; synchronizer latency is extra and acceptable).
REQ-019 SHALL, on wr_en=1 with full=1: leave wr_bin/wr_gray_ptr unchanged and drive overflow=1 for exactly that following cycle; overflow=0 otherwise.
REQ-020 SHALL treat a change of sync_rd_gray in the same cycle as an accepted write by evaluating REQ-016 with both new values.
REQ-021 SHALL have no combinational path from any input to any output.

Reset
REQ-022 SHALL, when rst=0 at a rising Src_clk edge, set wr_bin=0, wr_gray_ptr=0, full=0, overflow=0, almost_full=0, ignoring wr_en that cycle.
REQ-023 SHALL apply reset mid-operation with the same result; no write is accepted on a reset edge.
REQ-024 SHALL not reset asynchronously; outputs hold until the first edge with rst=0.

Configuration
REQ-025 SHALL compile almost_full logic and port only when macro WR_ALMOST_FULL_EN is defined.
REQ-026 SHALL, with WR_ALMOST_FULL_EN, convert sync_rd_gray to binary rd_bin (XOR prefix), compute level = wr_bin_next - rd_bin (ADDR_WIDTH+1 bits, modulo), and register almost_full = (level >= DEPTH - AF_MARGIN).
REQ-027 SHALL, without WR_ALMOST_FULL_EN, omit the almost_full port, the Gray-to-binary converter and the subtractor; all other behaviour identical.

Verification (ADDR_WIDTH=4, DEPTH=16, AF_MARGIN=2)
REQ-028 SHALL cover: rst=0 for 1 edge after random writes -> wr_addr=0, wr_gray_ptr=5'b00000, full=0, overflow=0.
REQ-029 SHALL cover: sync_rd_gray=0, 16 consecutive wr_en cycles -> full=1 after 16th edge, wr_gray_ptr=5'b11000, wr_addr=0.
REQ-030 SHALL cover: full=1, wr_en=1 for 3 cycles -> wr_gray_ptr stays 5'b11000, overflow=1 for 3 cycles, then 0.
REQ-031 SHALL cover: full=1, sync_rd_gray set to 5'b00001 -> full=0 one edge later; one further write -> full=1 again, wr_gray_ptr=5'b11001.
REQ-032 SHALL cover: 40 writes with sync_rd_gray tracking wr_gray_ptr two cycles behind -> full never asserts, wr_bin wraps 31->0 (wr_gray_ptr 5'b10000 -> 5'b00000), each step one-bit Gray change.
REQ-033 SHALL cover (WR_ALMOST_FULL_EN): sync_rd_gray=0, 14 writes -> almost_full=1 after 14th edge, full=0; after 13 writes almost_full=0.
